// File: rtl/spi_pkg.sv
// Shared SPI link definitions: default word width and slave/master state encoding.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus edge detection on the synced level.
module spi_sync_edge (
  input  logic clk_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  // Left unreset so a pin already held low across reset produces no spurious edge.
  always_ff @(posedge clk_i) begin
    sync1_q <= d_i;
    sync2_q <= sync1_q;
    prev_q  <= sync2_q;
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, oversampled in the clk domain, with a one-word TX holding buffer.
// Bit order: MSB first by default; SPI_SLAVE_LSB_FIRST_EN selects LSB first on both lines.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned           WIDTH      = SPI_WIDTH,
  parameter logic [WIDTH-1:0]      DEFAULT_TX = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sclk_i,
  input  logic             cs_n_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o
);

  localparam int unsigned      CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  LastBit = CntW'(WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge u_sync_sclk (
    .clk_i   (clk_i),
    .d_i     (sclk_i),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge u_sync_cs (
    .clk_i   (clk_i),
    .d_i     (cs_n_i),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk_i   (clk_i),
    .d_i     (mosi_i),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             word_done_q, word_done_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;

  logic             load;
  logic             tx_write;
  logic             miso_bit;
  logic [WIDTH-1:0] rx_shifted;
  logic [WIDTH-1:0] tx_shifted;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign miso_bit   = shift_tx_q[0];
  assign rx_shifted = {mosi_lvl, shift_rx_q[WIDTH-1:1]};
  assign tx_shifted = {1'b0, shift_tx_q[WIDTH-1:1]};
`else
  assign miso_bit   = shift_tx_q[WIDTH-1];
  assign rx_shifted = {shift_rx_q[WIDTH-2:0], mosi_lvl};
  assign tx_shifted = {shift_tx_q[WIDTH-2:0], 1'b0};
`endif

  assign tx_write = tx_valid_i & ~buf_full_q;

  always_comb begin
    state_d     = state_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    word_done_d = word_done_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    load        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StActive;
          load    = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise) begin
          // Partial word and the already-loaded TX word are dropped.
          state_d     = StIdle;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
        end else if (sclk_rise) begin
          shift_rx_d = rx_shifted;
          if (bit_cnt_q == LastBit) begin
            rx_data_d   = rx_shifted;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            load = 1'b1;
          end else begin
            shift_tx_d = tx_shifted;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A write in the same cycle as a load with an empty buffer is kept for the next word.
    if (load) begin
      shift_tx_d  = buf_full_q ? buf_q : DEFAULT_TX;
      bit_cnt_d   = '0;
      word_done_d = 1'b0;
    end

    if (load && buf_full_q) begin
      buf_full_d = 1'b0;
    end else if (tx_write) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      word_done_q <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      word_done_q <= word_done_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
    end
  end

  assign miso_oe_o  = (state_q == StActive);
  assign miso_o     = (state_q == StActive) ? miso_bit : 1'b0;
  assign busy_o     = (state_q == StActive);
  assign tx_ready_o = ~buf_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-word transfers plus multi-cycle corner sequences.
module tb_spi_slave;

  localparam int H = 8;  // clk cycles per sclk half period

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy;

  spi_slave #(
    .WIDTH      (8),
    .DEFAULT_TX (8'h00)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sclk_i     (sclk),
    .cs_n_i     (cs_n),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // rx_valid monitor: pulses, high cycles, last two words.
  int         rx_cnt = 0;
  int         rx_hi  = 0;
  logic       rx_prev_v = 1'b0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hi++;
      if (!rx_prev_v) begin
        rx_cnt++;
        rx_prev = rx_last;
        rx_last = rx_data;
      end
    end
    rx_prev_v = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tx_write_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master side: drive nbits of d, capture miso on each sclk rise.
  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      mosi = d[i];
`else
      mosi = d[7-i];
`endif
      repeat (H) @(negedge clk);
      sclk = 1'b1;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      cap[i] = miso;
`else
      cap[7-i] = miso;
`endif
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (H + 4) @(negedge clk);
  endtask

  typedef struct {
    logic       pre;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] cap, cap2;
  int         n0;

  initial begin
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[3] = '{1'b1, 8'hF0, 8'h0F, 8'h0F, 8'hF0};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single-word transfers.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].pre) begin
        tx_write(vecs[v].tx);
        check("vec_buf_full", {31'd0, tx_ready}, 32'd0);
      end
      n0 = rx_cnt;
      cs_low();
      spi_bits(vecs[v].mosi, 8, cap);
      cs_high();
      check("vec_rx_count", rx_cnt, n0 + 1);
      check("vec_rx_data", {24'd0, rx_last}, {24'd0, vecs[v].exp_rx});
      check("vec_miso_word", {24'd0, cap}, {24'd0, vecs[v].exp_miso});
      check("vec_tx_ready_end", {31'd0, tx_ready}, 32'd1);
    end

    // Two back-to-back words under one cs_n.
    tx_write(8'h12);
    n0 = rx_cnt;
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_tx_ready_after_cs", {31'd0, tx_ready}, 32'd1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_miso_oe", {31'd0, miso_oe}, 32'd1);
    tx_write(8'h34);
    repeat (H) @(negedge clk);
    spi_bits(8'hA5, 8, cap);
    spi_bits(8'h5A, 8, cap2);
    cs_high();
    check("b2b_rx_count", rx_cnt, n0 + 2);
    check("b2b_rx_first", {24'd0, rx_prev}, 32'hA5);
    check("b2b_rx_second", {24'd0, rx_last}, 32'h5A);
    check("b2b_miso_first", {24'd0, cap}, 32'h12);
    check("b2b_miso_second", {24'd0, cap2}, 32'h34);

    // Abort after 5 bits, then a clean word.
    n0 = rx_cnt;
    cs_low();
    spi_bits(8'hFF, 5, cap);
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("abort_miso", {31'd0, miso}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_rx", rx_cnt, n0);
    repeat (H) @(negedge clk);
    cs_low();
    spi_bits(8'hC3, 8, cap);
    cs_high();
    check("abort_next_rx_count", rx_cnt, n0 + 1);
    check("abort_next_rx_data", {24'd0, rx_last}, 32'hC3);

    // Reset mid-word, then sclk activity with cs_n still low.
    cs_low();
    spi_bits(8'hAA, 3, cap);
    tx_write(8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    n0 = rx_cnt;
    spi_bits(8'h96, 8, cap);
    repeat (4) @(negedge clk);
    check("postrst_no_rx", rx_cnt, n0);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    cs_n = 1'b1;
    repeat (H + 4) @(negedge clk);

    // First miso bit after cs_n fall for tx 8'h80, and word 8'h01 received.
    tx_write(8'h80);
    n0 = rx_cnt;
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    check("order_first_miso", {31'd0, miso}, 32'd0);
`else
    check("order_first_miso", {31'd0, miso}, 32'd1);
`endif
    repeat (H) @(negedge clk);
    spi_bits(8'h01, 8, cap);
    cs_high();
    check("order_rx_count", rx_cnt, n0 + 1);
    check("order_rx_data", {24'd0, rx_last}, 32'h01);
    check("order_miso_word", {24'd0, cap}, 32'h80);

    // Every rx_valid pulse lasted exactly one cycle.
    check("rx_valid_width", rx_hi, rx_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
